// File: rtl/sample_server_pkg.sv
// Shared types and default geometry for the sample server.
// Holds the FSM state enum and the default DEPTH/ADDR_W constants.
package sample_server_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/sample_server_if.sv
// Upstream write stream + sequencer bundle of the sample server.
// master: environment side (writer/sequencer); slave: the server.
interface sample_server_if
  import sample_server_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wr_valid;
  logic [31:0]       wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              seq_ready;
  logic              seq_start;
  logic              seq_inc;
  logic              seq_valid;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] seq_end_addr;
  logic [31:0]       seq_din;
  logic              busy;
  logic              done;
  logic              trunc;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_last,
    output seq_ready,
    output seq_inc,
    output seq_valid,
    input  wr_ready,
    input  seq_start,
    input  seq_addr,
    input  seq_end_addr,
    input  seq_din,
    input  busy,
    input  done,
    input  trunc
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_last,
    input  seq_ready,
    input  seq_inc,
    input  seq_valid,
    output wr_ready,
    output seq_start,
    output seq_addr,
    output seq_end_addr,
    output seq_din,
    output busy,
    output done,
    output trunc
  );

endinterface

// File: rtl/sample_ram.sv
// Sample buffer: one write port, one synchronous read port.
// Ports: clk/rst, wr_en/wr_addr/wr_data, rd_addr -> rd_data (1-cycle).
module sample_ram
  import sample_server_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Only the output register is reset; contents are left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_server.sv
// Buffers a block of samples, then serves them to a sequencer.
// Ports: clk, rst (sync, active-high), bus (sample_server_if.slave),
// replay (only with SAMPLE_SERVER_REPLAY_EN defined).
module sample_server
  import sample_server_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst,
`ifdef SAMPLE_SERVER_REPLAY_EN
  input  logic replay,
`endif
  sample_server_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(DEPTH - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              trunc_q, trunc_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              wr_ready;
  logic              wr_acc;
  logic              fresh;
  logic [ADDR_W-1:0] count_inc;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_rdata;

  assign count_inc = count_q + 1'b1;
  assign ptr_inc   = ptr_q + 1'b1;

  // A write here starts a new block at address 0.
`ifdef SAMPLE_SERVER_REPLAY_EN
  assign fresh = (state_q == S_IDLE) ||
                 (state_q == S_DONE);
`else
  assign fresh = (state_q == S_IDLE);
`endif

  always_comb begin
    wr_ready = 1'b0;
    unique case (state_q)
      S_IDLE,
      S_LOAD:  wr_ready = 1'b1;
`ifdef SAMPLE_SERVER_REPLAY_EN
      // Replay has priority over a new block.
      S_DONE:  wr_ready = !replay;
`endif
      default: wr_ready = 1'b0;
    endcase
    if (rst) begin
      wr_ready = 1'b0;
    end
  end

  assign wr_acc    = bus.wr_valid && wr_ready;
  assign ram_waddr = fresh ? '0 : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          state_d = bus.wr_last ? S_ARM : S_LOAD;
        end
      end
      S_LOAD: begin
        if (wr_acc &&
            (bus.wr_last || count_inc == LAST_IDX)) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.seq_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.seq_valid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
`ifdef SAMPLE_SERVER_REPLAY_EN
        if (replay) begin
          state_d = S_ARM;
        end else if (wr_acc) begin
          state_d = bus.wr_last ? S_ARM : S_LOAD;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_q;
    trunc_d = trunc_q;
    start_d = (state_q == S_ARM) && bus.seq_ready;
    busy_d  = (state_d == S_ARM) ||
              (state_d == S_RUN);
    done_d  = (state_d == S_DONE) &&
              (state_q != S_DONE);

    if (wr_acc && fresh) begin
      count_d = ADDR_W'(1);
      trunc_d = 1'b0;
    end else if (wr_acc && state_q == S_LOAD) begin
      count_d = count_inc;
      // Capacity hit without a closing word.
      if (count_inc == LAST_IDX && !bus.wr_last) begin
        trunc_d = 1'b1;
      end
    end

    if (state_d == S_IDLE) begin
      count_d = '0;
    end

    if (state_d == S_ARM) begin
      ptr_d = '0;
    end else if (state_q == S_RUN &&
                 !bus.seq_valid &&
                 bus.seq_inc &&
                 ptr_inc < count_q) begin
      ptr_d = ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ptr_q   <= '0;
      trunc_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ptr_q   <= ptr_d;
      trunc_q <= trunc_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (ram_waddr),
    .wr_data (bus.wr_data),
    .rd_addr (ptr_q),
    .rd_data (ram_rdata)
  );

  assign bus.wr_ready     = wr_ready;
  assign bus.seq_start    = start_q;
  assign bus.seq_addr     = ptr_q;
  assign bus.seq_end_addr = count_q;
  assign bus.seq_din      = ram_rdata;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.trunc        = trunc_q;

endmodule

// File: tb/tb_sample_server.sv
// Directed bench for sample_server.
// Define SAMPLE_SERVER_REPLAY_EN to also cover replay.
module tb_sample_server;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SAMPLE_SERVER_REPLAY_EN
  logic replay = 1'b0;
`endif

  int vectors    = 0;
  int miscompares = 0;

  sample_server_if #(.ADDR_W(10)) bus ();

  sample_server #(
    .DEPTH  (1024),
    .ADDR_W (10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef SAMPLE_SERVER_REPLAY_EN
    .replay (replay),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d,
                    input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic pulse_inc();
    bus.seq_inc = 1'b1;
    tick();
    bus.seq_inc = 1'b0;
  endtask

  task automatic arm_go();
    bus.seq_ready = 1'b1;
    tick();
    bus.seq_ready = 1'b0;
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_last   = 1'b0;
    bus.seq_ready = 1'b0;
    bus.seq_inc   = 1'b0;
    bus.seq_valid = 1'b0;

    tick();
    tick();
    chk("wr_ready_in_rst", 32'(bus.wr_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("rst_start", 32'(bus.seq_start), 0);
    chk("rst_addr", 32'(bus.seq_addr), 0);
    chk("rst_end", 32'(bus.seq_end_addr), 0);
    chk("rst_din", bus.seq_din, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_trunc", 32'(bus.trunc), 0);

    // Four-word block
    for (int i = 0; i < 4; i++) begin
      wr(32'h10 + 32'(i), i == 3);
      chk("b1_end", 32'(bus.seq_end_addr), 32'(i + 1));
    end
    chk("b1_busy", 32'(bus.busy), 1);
    chk("b1_wr_ready", 32'(bus.wr_ready), 0);
    chk("b1_din0", bus.seq_din, 32'h10);
    tick();
    chk("b1_no_start", 32'(bus.seq_start), 0);
    arm_go();
    chk("b1_start", 32'(bus.seq_start), 1);
    chk("b1_addr0", 32'(bus.seq_addr), 0);
    tick();
    chk("b1_start_off", 32'(bus.seq_start), 0);
    for (int k = 1; k < 4; k++) begin
      pulse_inc();
      chk("b1_addr", 32'(bus.seq_addr), 32'(k));
      chk("b1_din_lat", bus.seq_din,
          32'h10 + 32'(k - 1));
      tick();
      chk("b1_din", bus.seq_din, 32'h10 + 32'(k));
    end
    pulse_inc();
    chk("b1_sat", 32'(bus.seq_addr), 3);
    tick();
    chk("b1_sat_din", bus.seq_din, 32'h13);
    bus.seq_valid = 1'b1;
    tick();
    bus.seq_valid = 1'b0;
    chk("b1_done", 32'(bus.done), 1);
    chk("b1_busy_off", 32'(bus.busy), 0);
    tick();
    chk("b1_done_off", 32'(bus.done), 0);
    chk("b1_wr_ready_idle", 32'(bus.wr_ready), 1);
`ifdef SAMPLE_SERVER_REPLAY_EN
    chk("b1_end_hold", 32'(bus.seq_end_addr), 4);
`else
    chk("b1_end_clr", 32'(bus.seq_end_addr), 0);
`endif

    // Sequencer strobes outside RUN
    bus.seq_inc   = 1'b1;
    bus.seq_valid = 1'b1;
    tick();
    bus.seq_inc   = 1'b0;
    bus.seq_valid = 1'b0;
    chk("ign_addr", 32'(bus.seq_addr), 3);
    chk("ign_done", 32'(bus.done), 0);

    // inc and valid together
    for (int i = 0; i < 3; i++) begin
      wr(32'h20 + 32'(i), i == 2);
    end
    chk("b2_end", 32'(bus.seq_end_addr), 3);
    arm_go();
    pulse_inc();
    chk("b2_addr1", 32'(bus.seq_addr), 1);
    bus.seq_inc   = 1'b1;
    bus.seq_valid = 1'b1;
    tick();
    bus.seq_inc   = 1'b0;
    bus.seq_valid = 1'b0;
    chk("b2_done", 32'(bus.done), 1);
    chk("b2_addr_hold", 32'(bus.seq_addr), 1);
    tick();
    chk("b2_done_off", 32'(bus.done), 0);

    // Reset mid-RUN
    for (int i = 0; i < 4; i++) begin
      wr(32'h30 + 32'(i), i == 3);
    end
    arm_go();
    pulse_inc();
    pulse_inc();
    chk("b3_addr2", 32'(bus.seq_addr), 2);
    chk("b3_din", bus.seq_din, 32'h31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("b3_wr_ready", 32'(bus.wr_ready), 1);
    chk("b3_addr", 32'(bus.seq_addr), 0);
    chk("b3_end", 32'(bus.seq_end_addr), 0);
    chk("b3_din0", bus.seq_din, 0);
    chk("b3_busy", 32'(bus.busy), 0);
    chk("b3_start", 32'(bus.seq_start), 0);
    chk("b3_done", 32'(bus.done), 0);
    chk("b3_trunc", 32'(bus.trunc), 0);

    // Truncated 1023-word stream
    for (int i = 0; i < 1023; i++) begin
      wr(32'h1000 + 32'(i), 1'b0);
      if (i == 1021) begin
        chk("b4_pre_trunc", 32'(bus.trunc), 0);
        chk("b4_pre_ready", 32'(bus.wr_ready), 1);
        chk("b4_pre_end", 32'(bus.seq_end_addr), 1022);
      end
    end
    chk("b4_trunc", 32'(bus.trunc), 1);
    chk("b4_end", 32'(bus.seq_end_addr), 1023);
    chk("b4_wr_ready", 32'(bus.wr_ready), 0);
    chk("b4_busy", 32'(bus.busy), 1);
    arm_go();
    pulse_inc();
    tick();
    chk("b4_din1", bus.seq_din, 32'h1001);
    bus.seq_valid = 1'b1;
    tick();
    bus.seq_valid = 1'b0;
    tick();
    chk("b4_trunc_sticky", 32'(bus.trunc), 1);

    // Single-word block clears trunc
    wr(32'hAA, 1'b1);
    chk("b5_trunc_clr", 32'(bus.trunc), 0);
    chk("b5_end", 32'(bus.seq_end_addr), 1);
    chk("b5_busy", 32'(bus.busy), 1);
    arm_go();
    pulse_inc();
    chk("b5_sat0", 32'(bus.seq_addr), 0);
    tick();
    chk("b5_din", bus.seq_din, 32'hAA);
    bus.seq_valid = 1'b1;
    tick();
    bus.seq_valid = 1'b0;
    chk("b5_done", 32'(bus.done), 1);
    tick();
    chk("b5_done_off", 32'(bus.done), 0);
`ifdef SAMPLE_SERVER_REPLAY_EN
    chk("rp_end_hold", 32'(bus.seq_end_addr), 1);
    tick();
    chk("rp_still_done", 32'(bus.busy), 0);
    replay = 1'b1;
    tick();
    replay = 1'b0;
    chk("rp_busy", 32'(bus.busy), 1);
    arm_go();
    chk("rp_start", 32'(bus.seq_start), 1);
    chk("rp_addr", 32'(bus.seq_addr), 0);
    chk("rp_end", 32'(bus.seq_end_addr), 1);
`else
    chk("b5_end_clr", 32'(bus.seq_end_addr), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_server.md
SAMPLE_SERVER -- requirements
Module: sample_server

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, sample buffer depth in words.
REQ-002 SHALL have parameter ADDR_W, default 10, address/count width; DEPTH == 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_valid  input  1  upstream sample valid.
REQ-006 SHALL have port wr_data  input  32  upstream sample word.
REQ-007 SHALL have port wr_last  input  1  marks final word of a block.
REQ-008 SHALL have port wr_ready  output  1  buffer accepts writes.
REQ-009 SHALL have port seq_ready  input  1  sequencer idle and waiting for start.
REQ-010 SHALL have port seq_start  output  1  one-cycle start pulse to sequencer.
REQ-011 SHALL have port seq_inc  input  1  sequencer advance request, one-cycle pulse.
REQ-012 SHALL have port seq_valid  input  1  sequencer block complete.
REQ-013 SHALL have port seq_addr  output  ADDR_W  current read pointer.
REQ-014 SHALL have port seq_end_addr  output  ADDR_W  number of samples loaded.
REQ-015 SHALL have port seq_din  output  32  sample at seq_addr.
REQ-016 SHALL have port busy  output  1  high in ARM or RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse at block completion.
REQ-018 SHALL have port trunc  output  1  sticky: block truncated at capacity.

Function
REQ-019 SHALL implement states IDLE, LOAD, ARM, RUN, DONE.
REQ-020 SHALL drive wr_ready = 1 only in IDLE or LOAD and never while rst is high; a write is accepted when wr_valid && wr_ready.
REQ-021 IDLE: on accepted write SHALL store wr_data at address 0, set count = 1, go to LOAD (or ARM if wr_last).
REQ-022 LOAD: each accepted write SHALL store at address count, increment count; on wr_last, or when count reaches DEPTH-1, SHALL go to ARM.
REQ-023 Reaching count == DEPTH-1 without wr_last on that word SHALL set trunc; trunc clears only on next IDLE write or reset.
REQ-024 seq_end_addr SHALL equal count, updated in the cycle after each accepted write; range 1..DEPTH-1.
REQ-025 ARM: SHALL reset read pointer to 0; when seq_ready == 1 SHALL assert seq_start for exactly one cycle and go to RUN.
REQ-026 RUN: on seq_inc SHALL increment read pointer, saturating at count-1.
REQ-027 seq_din SHALL equal mem[seq_addr] with one-cycle read latency after seq_addr changes.
REQ-028 RUN: on seq_valid SHALL go to DONE; seq_valid and seq_inc in the same cycle: seq_valid wins, pointer unchanged.
REQ-029 DONE: SHALL pulse done for one cycle, then go to IDLE (see REQ-034) with count cleared.
REQ-030 seq_inc or seq_valid outside RUN SHALL be ignored.

Reset
REQ-031 On rst SHALL go to IDLE, clearing seq_start, seq_addr, seq_din, seq_end_addr, count, busy, done, trunc to 0.
REQ-032 Reset mid-LOAD or mid-RUN SHALL abandon the block; buffer contents need not be cleared.

Configuration
REQ-033 Macro SAMPLE_SERVER_REPLAY_EN SHALL add input port replay (1 bit).
REQ-034 With macro: DONE SHALL hold (done pulses once) until replay (go to ARM, same count) or accepted write (treated as IDLE write); without macro: DONE lasts one cycle, then IDLE.

Structure
REQ-035 Shared package sample_server_pkg SHALL hold state enum and default DEPTH/ADDR_W constants.
REQ-036 Buffer SHALL be sub-module sample_ram: one write port, one synchronous read port.

Verification
REQ-037 Load 4 words 0x10..0x13, wr_last on 4th -> seq_end_addr=4, seq_start one pulse after seq_ready=1.
REQ-038 In RUN, 3 seq_inc pulses -> seq_addr 1,2,3, seq_din 0x11,0x12,0x13 one cycle after each; 4th inc -> seq_addr stays 3.
REQ-039 Stream 1023 words without wr_last -> ARM, trunc=1, seq_end_addr=1023, wr_ready=0.
REQ-040 seq_inc and seq_valid together in RUN -> DONE, seq_addr unchanged, done one pulse.
REQ-041 rst during RUN at seq_addr=2 -> next cycle IDLE, all outputs 0, wr_ready=1.
REQ-042 With SAMPLE_SERVER_REPLAY_EN, replay in DONE -> seq_start pulse, seq_addr=0, seq_end_addr unchanged.
